instr_fetch: RTL

- Fetch stage. Owns the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Delivers pc, pc+4 and the instruction to decode.
- Consumer end of the execute-stage redirect interface (pc_next_sel, branch_jump_addr):
  - a taken branch or jump reloads the PC;
  - in-flight and buffered fetches are squashed.

---
 rtl/instr_fetch_pkg.sv | 17 +
 rtl/instr_fetch_skid_buf.sv | 33 +++
 rtl/instr_fetch.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared fetch-stage types and constants
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    localparam logic [31:0] FETCH_NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] FETCH_RESET_PC  = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/instr_fetch_skid_buf.sv
// rtl/instr_fetch_skid_buf.sv - one-entry holding buffer for a fetched instruction
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_pc_plus4,
    input  logic [31:0] d_instr,
    output logic        q_valid,
    output logic [31:0] q_pc,
    output logic [31:0] q_pc_plus4,
    output logic [31:0] q_instr
);

    // Clear wins over load so a redirect can never leave a stale entry behind
    always_ff @(posedge clk) begin
        if (rst) begin
            q_valid    <= 1'b0;
            q_pc       <= 32'h0;
            q_pc_plus4 <= 32'h0;
            q_instr    <= 32'h0;
        end else if (clear) begin
            q_valid <= 1'b0;
        end else if (load) begin
            q_valid    <= 1'b1;
            q_pc       <= d_pc;
            q_pc_plus4 <= d_pc_plus4;
            q_instr    <= d_instr;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, imem req/gnt/rvalid handshake, redirect squash
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = FETCH_RESET_PC,
    parameter logic [31:0] NOP_INSTR = FETCH_NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_next_sel,
    input  logic [31:0] branch_jump_addr,
    input  logic        stall_IF,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        valid_ID,
    output logic [31:0] pc_ID,
    output logic [31:0] pcPlus4_ID,
    output logic [31:0] instr_ID,
    output logic        misalign_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc_q;
    logic         grant;
    logic         rsp_valid;
    logic         buf_valid;
    logic         buf_load;
    logic         buf_clear;
    logic [31:0]  buf_pc;
    logic [31:0]  buf_pc_plus4;
    logic [31:0]  buf_instr;

    assign grant     = imem_req & imem_gnt;
    assign rsp_valid = (state_q == ST_WAIT) & imem_rvalid;
    assign imem_addr = word_align(pc_q);
    // A response that decode cannot take yet is parked; it drains on the first unstalled cycle
    assign buf_load  = rsp_valid & stall_IF & ~pc_next_sel;
    assign buf_clear = pc_next_sel | (buf_valid & ~stall_IF);

    // Request generation and next-state; at most one request is ever outstanding
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        case (state_q)
            ST_REQ: begin
                imem_req = ~buf_valid & ~pc_next_sel;
                if (imem_req & imem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Issue the next fetch in the same cycle the previous one returns
                imem_req = imem_rvalid & ~pc_next_sel & ~stall_IF;
                if (pc_next_sel) begin
                    state_d = imem_rvalid ? ST_REQ : ST_DROP;
                end else if (imem_rvalid) begin
                    state_d = (imem_req & imem_gnt) ? ST_WAIT : ST_REQ;
                end
            end
            ST_DROP: begin
                if (imem_rvalid) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
        if (rst) begin
            imem_req = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // PC update: redirect reloads, a granted fetch advances by one word
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            req_pc_q <= 32'h0;
        end else if (pc_next_sel) begin
            pc_q <= word_align(branch_jump_addr);
        end else if (grant) begin
            req_pc_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
        end
    end

    // Decode-facing registers; redirect squashes even when decode is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_ID   <= 1'b0;
            pc_ID      <= 32'h0;
            pcPlus4_ID <= 32'h0;
            instr_ID   <= NOP_INSTR;
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= pc_next_sel & (|branch_jump_addr[1:0]);
            if (pc_next_sel) begin
                valid_ID <= 1'b0;
                instr_ID <= NOP_INSTR;
            end else if (!stall_IF) begin
                if (buf_valid) begin
                    valid_ID   <= 1'b1;
                    pc_ID      <= buf_pc;
                    pcPlus4_ID <= buf_pc_plus4;
                    instr_ID   <= buf_instr;
                end else if (rsp_valid) begin
                    valid_ID   <= 1'b1;
                    pc_ID      <= req_pc_q;
                    pcPlus4_ID <= req_pc_q + 32'd4;
                    instr_ID   <= imem_rdata;
                end else begin
                    valid_ID <= 1'b0;
                    instr_ID <= NOP_INSTR;
                end
            end
        end
    end

    fetch_skid_buf u_skid_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .clear      (buf_clear),
        .d_pc       (req_pc_q),
        .d_pc_plus4 (req_pc_q + 32'd4),
        .d_instr    (imem_rdata),
        .q_valid    (buf_valid),
        .q_pc       (buf_pc),
        .q_pc_plus4 (buf_pc_plus4),
        .q_instr    (buf_instr)
    );

endmodule
